// File: rtl/plru_array_pkg.sv
// Shared types and helpers for the tree-PLRU replacement array.
package plru_array_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU logic: next node bits for an access, and victim
// selection from node bits with invalid ways taking priority.
module plru_tree
  import plru_array_pkg::*;
#(
  parameter  int WAYS   = 4,
  localparam int WAY_W  = (log2c(WAYS) < 1) ? 1 : log2c(WAYS),
  localparam int NODE_W = WAYS - 1
) (
  input  logic [NODE_W-1:0] node,
  input  logic [WAY_W-1:0]  way,
  input  logic [WAYS-1:0]   valid_mask,
  output logic [NODE_W-1:0] node_next,
  output logic [WAY_W-1:0]  victim
);

  logic [WAY_W-1:0] victim_tree;

  // Level d holds nodes (2^d - 1) .. (2^(d+1) - 2); path carries the way prefix walked so far.
  for (genvar d = 0; d < WAY_W; d++) begin : g_lvl
    localparam int BASE = (1 << d) - 1;
    localparam int N    = 1 << d;

    logic [WAY_W-1:0] prev;
    logic [WAY_W-1:0] path;
    logic [N-1:0]     lvl;
    logic [N-1:0]     lvl_sh;

    if (d == 0) begin : g_root
      assign prev = '0;
    end else begin : g_child
      assign prev = g_lvl[d-1].path;
    end

    assign lvl    = node[BASE +: N];
    assign lvl_sh = lvl >> prev;
    assign path   = (prev << 1) | WAY_W'(lvl_sh[0]);

    for (genvar j = 0; j < N; j++) begin : g_node
      assign node_next[BASE+j] = ((way >> (WAY_W - d)) == WAY_W'(j)) ?
                                 ~way[WAY_W-1-d] : node[BASE+j];
    end
  end

  assign victim_tree = g_lvl[WAY_W-1].path;

  always_comb begin
    victim = victim_tree;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_mask[i]) victim = WAY_W'(i);
    end
  end

endmodule

// File: rtl/plru_array.sv
// Per-set tree-PLRU replacement state with combinational victim lookup and a
// one-set-per-cycle clear sweep on reset or flush.
module plru_array
  import plru_array_pkg::*;
#(
  parameter  int WAYS   = 4,
  parameter  int SETS   = 256,
  localparam int IDX_W  = log2c(SETS),
  localparam int WAY_W  = (log2c(WAYS) < 1) ? 1 : log2c(WAYS),
  localparam int NODE_W = WAYS - 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_index,
  input  logic [WAYS-1:0]  rd_valid_mask,
  output logic [WAY_W-1:0] victim_way,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             flush_req,
  output logic             busy
);

  // Left without reset so the array can map onto distributed RAM.
  logic [NODE_W-1:0] node_mem [SETS];

  sweep_state_e      state, state_nxt;
  logic [IDX_W-1:0]  sweep_cnt, sweep_cnt_nxt;
  logic [NODE_W-1:0] rd_node, upd_node, upd_node_next;
  logic [WAY_W-1:0]  rd_victim, upd_victim_unused;
  logic [NODE_W-1:0] rd_next_unused;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= SWEEP;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt     = SWEEP;
          sweep_cnt_nxt = '0;
        end
      end
      SWEEP: begin
        sweep_cnt_nxt = sweep_cnt + 1'b1;
        if (sweep_cnt == IDX_W'(SETS - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SWEEP);

  // A flush in the same cycle as an update discards the update.
  always_ff @(posedge clk) begin
    if (busy) begin
      node_mem[sweep_cnt] <= '0;
    end else if (upd_en && !flush_req) begin
      node_mem[upd_index] <= upd_node_next;
    end
  end

  assign rd_node  = node_mem[rd_index];
  assign upd_node = node_mem[upd_index];

  plru_tree #(.WAYS(WAYS)) u_upd_tree (
    .node       (upd_node),
    .way        (upd_way),
    .valid_mask ({WAYS{1'b1}}),
    .node_next  (upd_node_next),
    .victim     (upd_victim_unused)
  );

  plru_tree #(.WAYS(WAYS)) u_rd_tree (
    .node       (rd_node),
    .way        ({WAY_W{1'b0}}),
    .valid_mask (rd_valid_mask),
    .node_next  (rd_next_unused),
    .victim     (rd_victim)
  );

  assign victim_way = busy ? '0 : rd_victim;

endmodule
